dmux_stream: RTL
================

// Module: dmux_stream
// PURPOSE
//  Parametrised, registered 1-to-CHANNELS demultiplexer with valid/ready flow control.
//  Steers a WIDTH-bit word to one output channel, or to all channels in broadcast mode.
//  Each channel has a one-entry output buffer, so producers and consumers are decoupled.
//  Sits between a single producer (for example, the CPU data path) and several consumers
//  (peripherals or memory banks). It replaces the purely combinational DMux16 where a
//  registered, back-pressured fan-out is needed.
// PARAMETERS
//  WIDTH     16  data word width in bits (>=1)
//  CHANNELS  4   number of output channels (2..2**SEL_W)
//  SEL_W     2   width of the channel-select field
// PORTS
//  clock       in   1                 rising-edge clock, single domain
//  reset       in   1                 synchronous, active-high
//  in_data     in   WIDTH             word to route
//  in_sel      in   SEL_W             target channel index
//  in_bcast    in   1                 1 = write to all channels (in_sel ignored)
//  in_valid    in   1                 producer offers word
//  in_ready    out  1                 block accepts word this cycle
//  out_data    out  CHANNELS*WIDTH    channel k = out_data[k*WIDTH +: WIDTH]
//  out_valid   out  CHANNELS          channel k holds a word
//  out_ready   in   CHANNELS          consumer k takes the word this cycle
//  drop_count  out  8                 saturating count of words dropped for a bad select
// BEHAVIOUR
//  - Per-channel state: EMPTY or FULL; out_valid[k] = (state[k] == FULL).
//  - Reset (sampled at a clock edge while reset=1):
//      all channels go to EMPTY; out_data = 0; drop_count = 0.
//      in_ready = 0 for as long as reset is high.
//      Reset mid-transfer discards all buffered words with no output handshake.
//  - free[k] = EMPTY[k] | out_ready[k]. A channel being drained may be refilled in the
//    same cycle, so full throughput is 1 word/cycle/channel.
//  - in_ready (combinational, no dependence on in_valid):
//      broadcast:              &free (all channels)
//      in_sel < CHANNELS:      free[in_sel]
//      in_sel >= CHANNELS:     1
//  - Accept = in_valid & in_ready. On the next edge:
//      unicast:   out_data[in_sel] <= in_data; channel goes to FULL.
//      broadcast: every channel loads in_data and goes to FULL.
//      bad select (in_sel >= CHANNELS, in_bcast=0): word is dropped; drop_count
//        increments, saturating at 255. No channel is touched.
//  - Latency: a word accepted at edge N shows out_valid=1 after edge N, i.e. one cycle.
//  - Drain: FULL & out_ready[k] & no refill -> EMPTY at the next edge.
//  - Stability: while out_valid[k]=1 and out_ready[k]=0, out_data[k] is held constant.
//  - Output data on EMPTY channels holds its last value; it is NOT zeroed
//    (unlike DMux16). Consumers must qualify data with out_valid.
//  - No reordering per channel; each channel holds at most one word.
//  - If in_valid=0, no state changes except drains.
// TESTING
//  1. Reset: hold reset for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0,
//     out_data=0, drop_count=0.
//  2. Unicast: in_data=16'hBEEF, in_sel=2, out_ready=0 -> after 1 clock
//     out_valid=4'b0100 and ch2=BEEF. Send a 2nd word to ch2: in_ready=0 and ch2
//     stays BEEF.
//  3. Back-to-back: ch1 with out_ready[1]=1 and 8 words 0..7, one per cycle ->
//     in_ready stays 1 and ch1 presents 0..7 in order, one per cycle.
//  4. Broadcast: in_bcast=1, data=16'h1234 with ch3 FULL -> in_ready=0. Once ch3
//     drains, the word is accepted and all 4 channels are valid with 1234.
//  5. Bad select: CHANNELS=3, in_sel=3, 300 words -> in_ready=1 every cycle,
//     out_valid=0, drop_count saturates at 255.
//  6. Reset mid-op: 3 channels FULL, pulse reset for 1 cycle -> out_valid=0 and
//     no out_valid pulse follows.

Source files
------------

// File: rtl/dmux_stream.sv
// dmux_stream: routes one WIDTH-bit word per cycle to a selected channel, or to every channel in broadcast mode.
// Latency: one cycle from the input handshake to out_valid on the target channel(s).
// Backpressure: in_ready falls when the target channel (any channel for broadcast) is full and not draining.
module dmux_stream #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [7:0]                drop_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    // free[k]: channel k can take a word this cycle (empty, or being drained right now)
    logic [CHANNELS-1:0] free;
    // sel_hit[k]: in_sel addresses populated channel k
    logic [CHANNELS-1:0] sel_hit;
    // load[k]: channel k captures in_data at the next edge
    logic [CHANNELS-1:0] load;
    logic                sel_ok;
    logic                sel_free;
    logic                accept;
    logic                drop;

    // Decode the select field against the channels that actually exist.
    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sel_hit[k] = (in_sel == SEL_W'(k));
        end
        sel_ok   = |sel_hit;
        sel_free = |(sel_hit & free);
    end

    // Ready depends only on target occupancy, never on in_valid; unmapped selects always sink.
    always_comb begin
        if (reset) begin
            in_ready = 1'b0;
        end else if (in_bcast) begin
            in_ready = &free;
        end else if (sel_ok) begin
            in_ready = sel_free;
        end else begin
            in_ready = 1'b1;
        end
    end

    assign accept = in_valid & in_ready;
    assign drop   = accept & ~in_bcast & ~sel_ok;
    assign load   = accept ? (in_bcast ? {CHANNELS{1'b1}} : sel_hit) : {CHANNELS{1'b0}};

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        chan_state_t      state_q;
        chan_state_t      state_d;
        logic [WIDTH-1:0] data_q;

        // Channel occupancy register.
        always_ff @(posedge clock) begin
            if (reset) begin
                state_q <= EMPTY;
            end else begin
                state_q <= state_d;
            end
        end

        // A refill wins over a drain so a slot being emptied can be reloaded in the same cycle.
        always_comb begin
            state_d = state_q;
            case (state_q)
                EMPTY:   if (load[k]) state_d = FULL;
                FULL:    if (!load[k] && out_ready[k]) state_d = EMPTY;
                default: state_d = EMPTY;
            endcase
        end

        // Data only changes on a load, so it is stable while stalled and keeps its last value when empty.
        always_ff @(posedge clock) begin
            if (reset) begin
                data_q <= '0;
            end else if (load[k]) begin
                data_q <= in_data;
            end
        end

        assign free[k]                      = (state_q == EMPTY) | out_ready[k];
        assign out_valid[k]                 = (state_q == FULL);
        assign out_data[k*WIDTH +: WIDTH]   = data_q;
    end

    // Saturating count of words discarded for an unmapped select.
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count <= 8'd0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule
